instr_decode: RTL and testbench

- Program store and instruction decode/execute stage that sits directly downstream of the 4-bit program counter.
- Consumes the counter's `count` (`pc`) and returns the counter's control inputs (`J`, `C`, `Cout`, `custom_input`) in the same cycle.
- Holds a 16x8 program memory, loaded through a programming port, plus the accumulator and carry flag.
- Drives the counter's active-high reset (`pc_rst`) while in program-load mode.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/prog_mem.sv | 44 ++++
 rtl/instr_decode.sv | 130 +++++++++++++
 tb/tb_instr_decode.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU slice: opcodes, FSM state encodings
// and instruction field positions.
package cpu_pkg;

  // Opcodes, instr[7:4]. Values 8-F decode as NOP.
  localparam logic [3:0] OPC_NOP = 4'h0;
  localparam logic [3:0] OPC_LDA = 4'h1;
  localparam logic [3:0] OPC_ADD = 4'h2;
  localparam logic [3:0] OPC_OUT = 4'h3;
  localparam logic [3:0] OPC_JMP = 4'h4;
  localparam logic [3:0] OPC_JC  = 4'h5;
  localparam logic [3:0] OPC_HLT = 4'h6;
  localparam logic [3:0] OPC_CLC = 4'h7;

  // FSM state encodings.
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // Instruction field positions.
  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 4;
  localparam int unsigned IMM_MSB = 3;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned TGT_MSB = 2;
  localparam int unsigned TGT_LSB = 0;

endpackage

// File: rtl/prog_mem.sv
// Program store: PROG_WORDS x INSTR_W register array.
//   clk_i    - clock
//   rst_ni   - synchronous active-low clear (all words to NOP)
//   we_i     - write strobe (already qualified by the caller)
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - asynchronous read data
module prog_mem #(
  parameter int unsigned PROG_WORDS = 16,
  parameter int unsigned INSTR_W    = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [3:0]         waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [3:0]         raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [PROG_WORDS];
  logic [INSTR_W-1:0] mem_d [PROG_WORDS];

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(PROG_WORDS); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_decode.sv
// Program store plus decode/execute stage for a 4-bit program counter.
// Control outputs (J, C, custom_input) are combinational from pc so the
// counter acts on them at the very next edge.
//   clk, reset      - clock, synchronous active-low reset
//   pc              - current counter value
//   prog_mode       - high selects program-load mode
//   prog_we/addr/data - program write port, honoured only while loading
//   pc_rst          - holds the counter at 0 while loading
//   J, C, custom_input - counter load requests and target
//   Cout            - carry register
//   acc, out_port, out_valid - accumulator, output register, write pulse
//   halted          - high in HALT
module instr_decode
  import cpu_pkg::*;
#(
  parameter int unsigned PROG_WORDS = 16,
  parameter int unsigned INSTR_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] pc,
  input  logic       prog_mode,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic       pc_rst,
  output logic       J,
  output logic       C,
  output logic       Cout,
  output logic [2:0] custom_input,
  output logic [3:0] acc,
  output logic [3:0] out_port,
  output logic       out_valid,
  output logic       halted
);

  logic [1:0]         state_q, state_d;
  logic [3:0]         acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [3:0]         out_q, out_d;
  logic               ov_q, ov_d;
  logic [INSTR_W-1:0] instr;
  logic [3:0]         opcode;
  logic [3:0]         imm;

  prog_mem #(
    .PROG_WORDS (PROG_WORDS),
    .INSTR_W    (INSTR_W)
  ) u_mem (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (prog_we && (state_q == ST_LOAD)),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc),
    .rdata_o (instr)
  );

  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign imm    = instr[IMM_MSB:IMM_LSB];

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    carry_d      = carry_q;
    out_d        = out_q;
    ov_d         = 1'b0;
    J            = 1'b0;
    C            = 1'b0;
    custom_input = '0;
    case (state_q)
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        custom_input = imm[TGT_MSB:TGT_LSB];
        case (opcode)
          OPC_LDA: acc_d = imm;
          OPC_ADD: {carry_d, acc_d} = 5'(acc_q) + 5'(imm);
          OPC_OUT: begin
            out_d = acc_q;
            ov_d  = 1'b1;
          end
          OPC_JMP: J = 1'b1;
          OPC_JC:  C = 1'b1;
          OPC_HLT: begin
            // Self-load on the HLT edge too, so a HLT at address >= 8 lands
            // once on pc-8 and the HALT self-loop then holds it there.
            J            = 1'b1;
            custom_input = pc[TGT_MSB:TGT_LSB];
            state_d      = ST_HALT;
          end
          OPC_CLC: carry_d = 1'b0;
          default: ;
        endcase
      end
      ST_HALT: begin
        J            = 1'b1;
        custom_input = pc[TGT_MSB:TGT_LSB];
      end
      default: state_d = ST_LOAD;
    endcase
    // Current instruction still executes; only the next state is overridden.
    if (prog_mode) begin
      state_d = ST_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      acc_q   <= '0;
      carry_q <= 1'b0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  assign pc_rst    = (state_q == ST_LOAD);
  assign halted    = (state_q == ST_HALT);
  assign Cout      = carry_q;
  assign acc       = acc_q;
  assign out_port  = out_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_instr_decode.sv
module tb_instr_decode;

  logic       clk;
  logic       reset;
  logic [3:0] pc;
  logic       prog_mode;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       pc_rst;
  logic       J;
  logic       C;
  logic       Cout;
  logic [2:0] custom_input;
  logic [3:0] acc;
  logic [3:0] out_port;
  logic       out_valid;
  logic       halted;

  int n_checks = 0;
  int n_fail   = 0;

  // Program counter: either a model of the external counter or forced.
  logic       use_model;
  logic [3:0] pc_model;
  logic [3:0] pc_force;
  assign pc = use_model ? pc_model : pc_force;

  instr_decode dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .prog_mode    (prog_mode),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .pc_rst       (pc_rst),
    .J            (J),
    .C            (C),
    .Cout         (Cout),
    .custom_input (custom_input),
    .acc          (acc),
    .out_port     (out_port),
    .out_valid    (out_valid),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pc_rst) pc_model <= 4'd0;
    else if (J || (C && Cout)) pc_model <= {1'b0, custom_input};
    else pc_model <= pc_model + 4'd1;
  end

  typedef struct packed {
    logic [3:0] pc;
    logic       j;
    logic       c;
    logic [2:0] tgt;
    logic [3:0] acc;
    logic       cout;
    logic       ov;
    logic [3:0] outp;
    logic       halt;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic pm);
    @(negedge clk);
    reset     = 1'b0;
    prog_mode = pm;
    step();
    reset = 1'b1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk);
    prog_mode = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; prog_mode = 1'b1; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; use_model = 1'b1; pc_force = '0;

    // Reset state
    do_reset(1'b1);
    check("rst_pc_rst", int'(pc_rst), 1);
    check("rst_acc", int'(acc), 0);
    check("rst_cout", int'(Cout), 0);
    check("rst_jc", int'({J, C}), 0);
    check("rst_ov", int'(out_valid), 0);
    check("rst_halted", int'(halted), 0);
    // Cleared memory executes as NOP everywhere.
    start_run();
    for (int i = 0; i < 16; i++) begin
      check("nop_jc", int'({J, C}), 0);
      check("nop_acc", int'(acc), 0);
      check("nop_pc", int'(pc), i);
      step();
    end
    check("nop_wrap", int'(pc), 0);

    // Main program: LDA 9, ADD 8, JC 5, OUT, HLT
    do_reset(1'b1);
    write_word(4'd0, 8'h19); write_word(4'd1, 8'h28); write_word(4'd2, 8'h55);
    write_word(4'd5, 8'h30); write_word(4'd6, 8'h60);
    start_run();
    check("a_pc0", int'(pc), 0);
    step(); check("a_acc9", int'(acc), 9); check("a_pc1", int'(pc), 1);
    step(); check("a_acc1", int'(acc), 1); check("a_cout1", int'(Cout), 1);
    check("a_C", int'(C), 1); check("a_tgt5", int'(custom_input), 5);
    step(); check("a_jump5", int'(pc), 5);
    step(); check("a_out", int'(out_port), 1); check("a_ov", int'(out_valid), 1);
    check("a_pc6", int'(pc), 6); check("a_hlt_J", int'(J), 1);
    check("a_hlt_tgt", int'(custom_input), 6); check("a_not_halted", int'(halted), 0);
    step(); check("a_halted", int'(halted), 1); check("a_ov_low", int'(out_valid), 0);
    check("a_pc_hold", int'(pc), 6);
    step(); check("a_pc_hold2", int'(pc), 6); check("a_halt_J", int'(J), 1);

    // JC without carry does not jump
    do_reset(1'b1);
    write_word(4'd0, 8'h19); write_word(4'd1, 8'h23); write_word(4'd2, 8'h55);
    start_run(); step(); step();
    check("b_acc12", int'(acc), 12); check("b_cout0", int'(Cout), 0);
    check("b_C", int'(C), 1);
    step(); check("b_no_jump", int'(pc), 3);
    // CLC after a carrying ADD
    do_reset(1'b1);
    write_word(4'd0, 8'h19); write_word(4'd1, 8'h28); write_word(4'd2, 8'h70);
    start_run(); step(); step();
    check("b_cout_set", int'(Cout), 1);
    step(); check("b_clc", int'(Cout), 0);

    // JMP at address 15, then plain wrap
    do_reset(1'b1);
    write_word(4'd15, 8'h43);
    start_run();
    for (int i = 0; i < 15; i++) step();
    check("c_pc15", int'(pc), 15); check("c_J", int'(J), 1);
    check("c_tgt3", int'(custom_input), 3);
    step(); check("c_jump3", int'(pc), 3);
    do_reset(1'b1);
    start_run();
    for (int i = 0; i < 15; i++) step();
    check("c_pc15b", int'(pc), 15); check("c_noJ", int'(J), 0);
    step(); check("c_wrap", int'(pc), 0);

    // Writes ignored in RUN, prog_mode mid-run, reset mid-run
    do_reset(1'b1);
    write_word(4'd0, 8'h15); write_word(4'd1, 8'h2F);
    write_word(4'd2, 8'h30); write_word(4'd3, 8'h40);
    start_run(); step(); step();
    check("d_acc4", int'(acc), 4); check("d_cout", int'(Cout), 1);
    write_word(4'd0, 8'hFF);
    step(); check("d_loop", int'(pc), 0);
    step(); check("d_mem_kept", int'(acc), 5);
    step(); step(); check("d_out4", int'(out_port), 4); check("d_pc3", int'(pc), 3);
    @(negedge clk); prog_mode = 1'b1;
    step();
    check("d_load", int'(pc_rst), 1); check("d_acc_kept", int'(acc), 4);
    check("d_cout_kept", int'(Cout), 1); check("d_load_J", int'(J), 0);
    start_run(); step(); step();
    check("d_acc_rerun", int'(acc), 4);
    do_reset(1'b0);
    check("d_rst_load", int'(pc_rst), 1); check("d_rst_acc", int'(acc), 0);
    check("d_rst_cout", int'(Cout), 0); check("d_rst_out", int'(out_port), 0);

    // HLT at address 10
    do_reset(1'b1);
    write_word(4'd10, 8'h60);
    start_run();
    for (int i = 0; i < 10; i++) step();
    check("e_pc10", int'(pc), 10); check("e_J", int'(J), 1);
    check("e_tgt2", int'(custom_input), 2);
    step(); check("e_pc2", int'(pc), 2); check("e_halted", int'(halted), 1);
    step(); check("e_hold", int'(pc), 2); check("e_halted2", int'(halted), 1);
    @(negedge clk); prog_mode = 1'b1;
    step(); check("e_load", int'(pc_rst), 1); check("e_unhalt", int'(halted), 0);

    // Table-driven decode with forced pc
    tbl[0]  = '{4'd0,  1'b0, 1'b0, 3'd0, 4'd9, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{4'd1,  1'b0, 1'b0, 3'd0, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{4'd2,  1'b0, 1'b1, 3'd5, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[3]  = '{4'd5,  1'b0, 1'b0, 3'd0, 4'd1, 1'b1, 1'b1, 4'd1, 1'b0};
    tbl[4]  = '{4'd3,  1'b0, 1'b0, 3'd0, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[5]  = '{4'd2,  1'b0, 1'b1, 3'd5, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[6]  = '{4'd4,  1'b1, 1'b0, 3'd3, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[7]  = '{4'd6,  1'b0, 1'b0, 3'd0, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[8]  = '{4'd7,  1'b0, 1'b0, 3'd0, 4'd4, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[9]  = '{4'd9,  1'b0, 1'b0, 3'd0, 4'd3, 1'b1, 1'b0, 4'd1, 1'b0};
    tbl[10] = '{4'd10, 1'b0, 1'b1, 3'd1, 4'd3, 1'b1, 1'b0, 4'd1, 1'b0};
    tbl[11] = '{4'd8,  1'b0, 1'b0, 3'd0, 4'd3, 1'b1, 1'b0, 4'd1, 1'b0};
    tbl[12] = '{4'd11, 1'b1, 1'b0, 3'd3, 4'd3, 1'b1, 1'b0, 4'd1, 1'b1};
    do_reset(1'b1);
    write_word(4'd0, 8'h19); write_word(4'd1, 8'h28); write_word(4'd2, 8'h55);
    write_word(4'd3, 8'h7F); write_word(4'd4, 8'h4B); write_word(4'd5, 8'h30);
    write_word(4'd6, 8'h8A); write_word(4'd7, 8'h23); write_word(4'd8, 8'h00);
    write_word(4'd9, 8'h2F); write_word(4'd10, 8'h51); write_word(4'd11, 8'h60);
    start_run();
    use_model = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      pc_force = tbl[i].pc;
      #1;
      check($sformatf("t%0d_J", i), int'(J), int'(tbl[i].j));
      check($sformatf("t%0d_C", i), int'(C), int'(tbl[i].c));
      if (tbl[i].j || tbl[i].c)
        check($sformatf("t%0d_tgt", i), int'(custom_input), int'(tbl[i].tgt));
      step();
      check($sformatf("t%0d_acc", i), int'(acc), int'(tbl[i].acc));
      check($sformatf("t%0d_cout", i), int'(Cout), int'(tbl[i].cout));
      check($sformatf("t%0d_ov", i), int'(out_valid), int'(tbl[i].ov));
      check($sformatf("t%0d_out", i), int'(out_port), int'(tbl[i].outp));
      check($sformatf("t%0d_halt", i), int'(halted), int'(tbl[i].halt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
